maj_netlist_sequencer: RTL and testbench
========================================

// Module: maj_netlist_sequencer
// PURPOSE
//  Evaluates a programmable 7-input majority-gate netlist by time-multiplexing one MAJ3 cell, one gate per cycle.
//  Holds a small gate program, captures an input vector via valid/ready, computes the gates in order and returns the selected 1-bit result.
//  Sits beside the fixed combinational majority networks; it is the reconfigurable scheduler used to sweep candidate netlists for a function class.
// PARAMETERS
//  NUM_IN     7   primary inputs x0..x(NUM_IN-1)
//  MAX_GATES  8   gate program depth
//  IDX_W      4   signal index width; needs 1+NUM_IN+MAX_GATES <= 2**IDX_W
// PORTS
//  clk          in   1                 clock, all state on rising edge
//  rst_n        in   1                 asynchronous active-low reset
//  prog_we      in   1                 write one gate instruction
//  prog_addr    in   $clog2(MAX_GATES) gate slot to write
//  prog_data    in   3*(IDX_W+1)       {opC,opB,opA}; operand = {inv, idx}
//  cfg_len      in   $clog2(MAX_GATES+1) number of gates to evaluate (0..MAX_GATES)
//  cfg_out_sel  in   IDX_W+1           {inv, idx} of signal driven to out
//  prog_busy    out  1                 high when not IDLE; program writes ignored
//  in_valid     in   1                 input vector offered
//  in_ready     out  1                 high only in IDLE
//  x            in   NUM_IN            input vector, bit i = x_i
//  out_valid    out  1                 result valid (DONE)
//  out_ready    in   1                 consumer accepts result
//  out          out  1                 result bit
// BEHAVIOUR
//  Signal file: idx 0 = constant 0; 1..NUM_IN = x0..x(NUM_IN-1); NUM_IN+1+k = gate g_k. Operand value = sig[idx] ^ inv.
//  Gate k: g_k = MAJ(a,b,c) = ab|ac|bc of its three operands; written to sig[NUM_IN+1+k].
//  Reset (async, rst_n=0): state IDLE; in_ready=1, out_valid=0, out=0, prog_busy=0; all program slots, gate flops, captured x, len and sel cleared to 0.
//  FSM: IDLE -> EVAL on in_valid&in_ready (if cfg_len==0 go straight to DONE). EVAL -> DONE after gate cfg_len-1 is written. DONE -> IDLE on out_ready.
//  Capture (handshake cycle T): x, cfg_len, cfg_out_sel latched; gate flops g_0..g_(MAX_GATES-1) cleared to 0; gate_ptr=0.
//  EVAL: one gate per cycle, gate_ptr increments; cfg changes during EVAL/DONE have no effect.
//  Latency: out_valid rises at cycle T+cfg_len+1 (T+1 when cfg_len=0); out is registered = sel value, stable while out_valid&!out_ready.
//  Forward references (operand idx of a gate not yet computed, or beyond cfg_len) read 0 (cleared value), inverted if inv=1.
//  cfg_len > MAX_GATES saturates to MAX_GATES.
//  prog_we honoured only in IDLE; in EVAL/DONE it is dropped silently (prog_busy=1). prog_we in the same cycle as an input handshake takes effect (program write happens, evaluation uses new contents).
//  No overlap: in_ready=0 in EVAL and DONE; one bubble cycle (IDLE) between consecutive results.
//  Reset asserted mid-EVAL/DONE: immediate return to reset values; pending result discarded; program must be reloaded.
// STRUCTURE
//  Package maj_sched_pkg: operand_t {inv, idx}, gate_instr_t {opA,opB,opC}, state_e {IDLE,EVAL,DONE}, index constants IDX_CONST0, IDX_X0, IDX_G0.
//  Sub-module maj3_cell: combinational a,b,c -> ab|ac|bc, single instance shared by all gates.
//  Top: program regfile, signal-file mux (3 read ports + out_sel port), FSM, gate_ptr counter.
// TESTING
//  Program P: g0=MAJ(x2,x5,x6) g1=MAJ(x2,x3,x4) g2=MAJ(x2,g0,g1) g3=MAJ(x0,x1,g1) g4=MAJ(x0,g2,g3); cfg_len=5, cfg_out_sel=g4.
//  P, x: x0=x2=x3=1, others 0 -> out=1, out_valid exactly 6 cycles after handshake.
//  P, x: x0=1 only -> out=0; x=7'h00 -> out=0; exhaustive 128 vectors vs golden model of P.
//  cfg_len=0, cfg_out_sel={inv=1,idx=0} -> out=1 one cycle after handshake; {inv=0,idx=3 (x2)} with x2=1 -> out=1.
//  Backpressure: hold out_ready=0 for 10 cycles -> out_valid/out stable, in_ready=0, prog_we writes during that time ignored (readback via next run unchanged).
//  rst_n pulsed low mid-EVAL (gate 2 of P) -> out_valid=0, in_ready=1 immediately; next run with no reload yields out=0 (cleared program).

Source files
------------

// File: rtl/maj_netlist_sequencer_pkg.sv
// Shared types and index map for the time-multiplexed majority netlist sequencer.
// The signal file is laid out as: constant 0, then the primary inputs, then the gate outputs.
package maj_sched_pkg;

  localparam int NUM_IN_DEF    = 7;
  localparam int MAX_GATES_DEF = 8;
  localparam int IDX_W_DEF     = 4;

  localparam int IDX_CONST0 = 0;
  localparam int IDX_X0     = 1;
  localparam int IDX_G0     = IDX_X0 + NUM_IN_DEF;

  typedef struct packed {
    logic                 inv;
    logic [IDX_W_DEF-1:0] idx;
  } operand_t;

  // opC occupies the MSBs, so a packed instruction word reads {opC, opB, opA}.
  typedef struct packed {
    operand_t opC;
    operand_t opB;
    operand_t opA;
  } gate_instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/maj_netlist_sequencer_maj3_cell.sv
// Single three-input majority cell; the sequencer shares one instance across all gates.
module maj3_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/maj_netlist_sequencer.sv
// Evaluates a programmable majority-gate netlist one gate per cycle through a shared MAJ3 cell.
// Input vectors arrive via valid/ready; the selected signal is returned as a registered 1-bit result.
module maj_netlist_sequencer
  import maj_sched_pkg::*;
#(
  parameter int NUM_IN    = NUM_IN_DEF,
  parameter int MAX_GATES = MAX_GATES_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             prog_we,
  input  logic [$clog2(MAX_GATES)-1:0]     prog_addr,
  input  logic [3*(IDX_W+1)-1:0]           prog_data,
  input  logic [$clog2(MAX_GATES+1)-1:0]   cfg_len,
  input  logic [IDX_W:0]                   cfg_out_sel,
  output logic                             prog_busy,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_IN-1:0]                x,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out
);

  localparam int ADDR_W = $clog2(MAX_GATES);
  localparam int LEN_W  = $clog2(MAX_GATES + 1);
  localparam int SIG_N  = 2 ** IDX_W;
  localparam int G0     = IDX_X0 + NUM_IN;

  gate_instr_t [MAX_GATES-1:0] r_prog;
  logic [MAX_GATES-1:0]        r_gate, w_gate_next;
  logic [NUM_IN-1:0]           r_x, w_x_next;
  logic [LEN_W-1:0]            r_len, w_len_next, w_cfg_len_sat;
  operand_t                    r_sel, w_sel_next;
  logic [ADDR_W-1:0]           r_ptr, w_ptr_next;
  state_e                      r_state, w_state_next;
  logic                        r_out, w_out_next;

  logic [SIG_N-1:0] w_sig;
  logic [SIG_N-1:0] w_sig_next;
  gate_instr_t      w_instr;
  logic             w_a, w_b, w_c, w_maj, w_last;

  // Two views of the signal file: current flops for operand reads, next-state values
  // so the result register can include the gate being written on the final EVAL edge.
  genvar gi;
  generate
    for (gi = 0; gi < SIG_N; gi++) begin : g_sig
      if (gi == IDX_CONST0) begin : g_const
        assign w_sig[gi]      = 1'b0;
        assign w_sig_next[gi] = 1'b0;
      end else if (gi < G0) begin : g_in
        assign w_sig[gi]      = r_x[gi-IDX_X0];
        assign w_sig_next[gi] = w_x_next[gi-IDX_X0];
      end else if (gi < G0 + MAX_GATES) begin : g_gate
        assign w_sig[gi]      = r_gate[gi-G0];
        assign w_sig_next[gi] = w_gate_next[gi-G0];
      end else begin : g_pad
        assign w_sig[gi]      = 1'b0;
        assign w_sig_next[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_instr = r_prog[r_ptr];
  assign w_a     = w_sig[w_instr.opA.idx] ^ w_instr.opA.inv;
  assign w_b     = w_sig[w_instr.opB.idx] ^ w_instr.opB.inv;
  assign w_c     = w_sig[w_instr.opC.idx] ^ w_instr.opC.inv;

  maj3_cell u_maj3 (
    .a (w_a),
    .b (w_b),
    .c (w_c),
    .y (w_maj)
  );

  assign w_cfg_len_sat = (cfg_len > LEN_W'(MAX_GATES)) ? LEN_W'(MAX_GATES) : cfg_len;
  assign w_last        = (LEN_W'(r_ptr) == (r_len - LEN_W'(1)));

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_gate_next  = r_gate;
    w_x_next     = r_x;
    w_len_next   = r_len;
    w_sel_next   = r_sel;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_x_next     = x;
          w_len_next   = w_cfg_len_sat;
          w_sel_next   = operand_t'(cfg_out_sel);
          w_gate_next  = '0;
          w_ptr_next   = '0;
          w_state_next = (w_cfg_len_sat == '0) ? DONE : EVAL;
        end
      end
      EVAL: begin
        w_gate_next[r_ptr] = w_maj;
        w_ptr_next         = r_ptr + ADDR_W'(1);
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_out_next = (w_state_next == DONE) ? (w_sig_next[w_sel_next.idx] ^ w_sel_next.inv) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gate  <= '0;
      r_x     <= '0;
      r_len   <= '0;
      r_sel   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_gate  <= w_gate_next;
      r_x     <= w_x_next;
      r_len   <= w_len_next;
      r_sel   <= w_sel_next;
      r_out   <= w_out_next;
    end
  end

  // A write coinciding with the input handshake still lands before the first EVAL read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prog <= '0;
    end else if (prog_we && (r_state == IDLE)) begin
      r_prog[prog_addr] <= gate_instr_t'(prog_data);
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign prog_busy = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign out       = r_out;

endmodule

// File: tb/tb_maj_netlist_sequencer.sv
// Self-checking bench for maj_netlist_sequencer: scoreboard of expected results,
// latency, backpressure, program-lock, same-cycle write and mid-run reset scenarios.
module tb_maj_netlist_sequencer;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [2:0]  prog_addr;
  logic [14:0] prog_data;
  logic [3:0]  cfg_len;
  logic [4:0]  cfg_out_sel;
  logic        prog_busy;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  x;
  logic        out_valid;
  logic        out_ready;
  logic        out;

  int   vectors;
  int   miscompares;
  logic exp_q[$];

  localparam logic [4:0] SEL_G4 = 5'd12;

  maj_netlist_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .cfg_len     (cfg_len),
    .cfg_out_sel (cfg_out_sel),
    .prog_busy   (prog_busy),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Reference evaluation of program P, written directly from its gate list.
  function automatic logic model_p(input logic [6:0] v);
    logic g0, g1, g2, g3;
    g0 = maj(v[2], v[5], v[6]);
    g1 = maj(v[2], v[3], v[4]);
    g2 = maj(v[2], g0, g1);
    g3 = maj(v[0], v[1], g1);
    return maj(v[0], g2, g3);
  endfunction

  function automatic logic [14:0] instr(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {c, b, a};
  endfunction

  task automatic prog_write(input logic [2:0] addr, input logic [14:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic load_p();
    prog_write(3'd0, instr(5'd3, 5'd6,  5'd7));
    prog_write(3'd1, instr(5'd3, 5'd4,  5'd5));
    prog_write(3'd2, instr(5'd3, 5'd8,  5'd9));
    prog_write(3'd3, instr(5'd1, 5'd2,  5'd9));
    prog_write(3'd4, instr(5'd1, 5'd10, 5'd11));
  endtask

  // One transaction: handshake, latency count, optional backpressure hold, result check.
  task automatic run_vec(input logic [6:0] xv, input logic [3:0] len, input logic [4:0] sel,
                         input logic expv, input int lat, input int bp,
                         input logic hs_we, input logic [14:0] hs_data);
    int   n;
    logic held;
    logic expo;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
    end
    x           = xv;
    cfg_len     = len;
    cfg_out_sel = sel;
    in_valid    = 1'b1;
    out_ready   = (bp == 0);
    if (hs_we) begin
      prog_we   = 1'b1;
      prog_addr = 3'd4;
      prog_data = hs_data;
    end
    exp_q.push_back(expv);
    @(negedge clk);
    in_valid    = 1'b0;
    prog_we     = 1'b0;
    x           = 7'($urandom);
    cfg_len     = 4'($urandom);
    cfg_out_sel = 5'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      vectors++;
      if (in_ready !== 1'b0 || prog_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_flags: in_ready=%b prog_busy=%b required 0/1", in_ready, prog_busy);
      end
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!out_valid || n != lat) begin
      miscompares++;
      $display("FAIL latency x=%h len=%0d: out_valid=%b after %0d cycles, required %0d", xv, len, out_valid, n, lat);
    end
    if (out_valid && bp > 0) begin
      held = out;
      for (int i = 0; i < bp; i++) begin
        prog_we   = 1'b1;
        prog_addr = 3'd4;
        prog_data = '1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out !== held || in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL hold: out_valid=%b out=%b in_ready=%b required 1/%b/0", out_valid, out, in_ready, held);
        end
      end
      prog_we   = 1'b0;
      out_ready = 1'b1;
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: result with no expected entry");
    end else begin
      expo = exp_q.pop_front();
      if (out !== expo) begin
        miscompares++;
        $display("FAIL result x=%h len=%0d sel=%h: out=%b required %b", xv, len, sel, out, expo);
      end
    end
    $display("txn x=%h len=%0d sel=%h exp=%b out=%b lat=%0d", xv, len, sel, expv, out, n);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    cfg_len = '0; cfg_out_sel = '0; in_valid = 1'b0; x = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 1'b0 || prog_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out=%b prog_busy=%b required 1/0/0/0",
               in_ready, out_valid, out, prog_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_vec(7'h0D, 4'd5, SEL_G4, 1'b1, 6, 0, 1'b0, '0);
    run_vec(7'h01, 4'd5, SEL_G4, 1'b0, 6, 0, 1'b0, '0);
    run_vec(7'h00, 4'd5, SEL_G4, 1'b0, 6, 0, 1'b0, '0);
  endtask

  task automatic test_exhaustive();
    for (int i = 0; i < 128; i++) begin
      run_vec(7'(i), 4'd5, SEL_G4, model_p(7'(i)), 6, 0, 1'b0, '0);
    end
  endtask

  task automatic test_len_zero();
    run_vec(7'h55, 4'd0, 5'b1_0000, 1'b1, 1, 0, 1'b0, '0);
    run_vec(7'h04, 4'd0, 5'b0_0011, 1'b1, 1, 0, 1'b0, '0);
    run_vec(7'h7B, 4'd0, 5'b0_0011, 1'b0, 1, 0, 1'b0, '0);
  endtask

  task automatic test_saturate();
    run_vec(7'h0D, 4'd15, SEL_G4, 1'b1, 9, 0, 1'b0, '0);
    run_vec(7'h01, 4'd9,  SEL_G4, 1'b0, 9, 0, 1'b0, '0);
  endtask

  task automatic test_backpressure();
    run_vec(7'h0D, 4'd5, SEL_G4, 1'b1, 6, 10, 1'b0, '0);
    // An accepted write during the hold would force g4 to 1 here.
    run_vec(7'h00, 4'd5, SEL_G4, 1'b0, 6, 0, 1'b0, '0);
  endtask

  task automatic test_prog_on_handshake();
    run_vec(7'h00, 4'd5, SEL_G4, 1'b1, 6, 0, 1'b1, instr(5'b1_0000, 5'b1_0000, 5'b1_0000));
    prog_write(3'd4, instr(5'd1, 5'd10, 5'd11));
    run_vec(7'h00, 4'd5, SEL_G4, 1'b0, 6, 0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] v;
    for (int i = 0; i < 6; i++) begin
      v = 7'($urandom);
      run_vec(v, 4'd5, SEL_G4, model_p(v), 6, 0, 1'b0, '0);
    end
  endtask

  task automatic test_reset_mid_eval();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    x = 7'h0D; cfg_len = 4'd5; cfg_out_sel = SEL_G4; in_valid = 1'b1;
    exp_q.push_back(1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || prog_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_eval: out_valid=%b in_ready=%b prog_busy=%b required 0/1/0",
               out_valid, in_ready, prog_busy);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(7'h0D, 4'd5, SEL_G4, 1'b0, 6, 0, 1'b0, '0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    load_p();
    test_basic();
    test_exhaustive();
    test_len_zero();
    test_saturate();
    test_backpressure();
    test_prog_on_handshake();
    test_back_to_back();
    test_reset_mid_eval();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
